// File: rtl/measure_rx_if.sv
// XGMII receive bus bundle: 64-bit data plus per-lane control qualifiers.
interface measure_rx_if;
  logic [63:0] xgmii_rxd;
  logic [7:0]  xgmii_rxc;

  modport master (output xgmii_rxd, output xgmii_rxc);
  modport slave  (input  xgmii_rxd, input  xgmii_rxc);
endinterface

// File: rtl/measure_rx.sv
// XGMII receive measurement engine: validates IPv4/UDP test frames and reports
// per-second frame/byte counts, one-way latency and last source address.
module measure_rx #(
  parameter logic [39:0] MAGIC_CODE = 40'h0,
  parameter logic [15:0] UDP_PORT   = 16'd3422
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               sec_oneshot,
  input  logic [31:0]        global_counter,
  measure_rx_if.slave        xgmii,
  output logic [31:0]        rx_pps,
  output logic [31:0]        rx_throughput,
  output logic [23:0]        rx_latency,
  output logic [31:0]        rx_ipv4_ip,
  output logic [15:0]        rx_err_count
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_DROP} state_t;

  state_t      state;
  logic [28:0] wcnt;
  logic        frame_ok;
  logic [7:0]  ts_hi;
  logic [23:0] lat_pend;
  logic [31:0] src_ip;
  logic [31:0] frame_cnt;
  logic [31:0] byte_cnt;

  logic [7:0]  lane [8];
  logic [7:0]  rxc;
  logic        is_start, idle_word, term_hit, ctrl_bad, seen, term_ok, abort;
  logic [2:0]  term_lane;
  logic        chk_ok, in_frame, commit, err_inc;
  logic [31:0] ts_now, lat_diff, commit_bytes;
  logic [23:0] lat_now;

  assign rxc = xgmii.xgmii_rxc;

  // Lowest control lane must be the terminate; any later control lane must be idle.
  always_comb begin
    term_hit  = 1'b0;
    term_lane = '0;
    ctrl_bad  = 1'b0;
    seen      = 1'b0;
    idle_word = 1'b1;
    for (int unsigned i = 0; i < 8; i++) begin
      lane[i] = xgmii.xgmii_rxd[8*i +: 8];
      if (!(rxc[i] && lane[i] == 8'h07)) idle_word = 1'b0;
      if (rxc[i]) begin
        if (!seen) begin
          seen = 1'b1;
          if (lane[i] == 8'hFD) begin
            term_hit  = 1'b1;
            term_lane = 3'(i);
          end else begin
            ctrl_bad = 1'b1;
          end
        end else if (lane[i] != 8'h07) begin
          ctrl_bad = 1'b1;
        end
      end
    end
  end

  assign is_start = (rxc == 8'h01) && (lane[0] == 8'hFB);
  assign term_ok  = term_hit && !ctrl_bad;
  assign abort    = (|rxc) && !term_ok;

  always_comb begin
    chk_ok = 1'b1;
    case (wcnt)
      29'd2: chk_ok = {lane[4], lane[5], lane[6], lane[7]} == 32'h0800_4500;
      29'd3: chk_ok = lane[7] == 8'h11;
      29'd5: chk_ok = {lane[2], lane[3]} == UDP_PORT && {lane[4], lane[5]} == UDP_PORT;
      29'd6: chk_ok = {lane[2], lane[3], lane[4], lane[5], lane[6]} == MAGIC_CODE;
      default: chk_ok = 1'b1;
    endcase
  end

  assign ts_now   = {ts_hi, lane[0], lane[1], lane[2]};
  assign lat_diff = global_counter - ts_now;
  assign lat_now  = (|lat_diff[31:24]) ? 24'hFFFFFF : lat_diff[23:0];

  assign in_frame     = (state == S_HDR) || (state == S_BODY);
  assign commit       = in_frame && !is_start && term_ok && frame_ok && (wcnt >= 29'd7);
  assign err_inc      = in_frame && (is_start || abort);
  assign commit_bytes = {wcnt - 29'd1, 3'b000} + {29'd0, term_lane};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state         <= S_IDLE;
      wcnt          <= '0;
      frame_ok      <= 1'b0;
      ts_hi         <= '0;
      lat_pend      <= '0;
      src_ip        <= '0;
      frame_cnt     <= '0;
      byte_cnt      <= '0;
      rx_pps        <= '0;
      rx_throughput <= '0;
      rx_latency    <= '0;
      rx_ipv4_ip    <= '0;
      rx_err_count  <= '0;
    end else begin
      if (sec_oneshot) begin
        rx_pps        <= frame_cnt + {31'd0, commit};
        rx_throughput <= byte_cnt + (commit ? commit_bytes : '0);
        frame_cnt     <= '0;
        byte_cnt      <= '0;
      end else begin
        frame_cnt <= frame_cnt + {31'd0, commit};
        byte_cnt  <= byte_cnt + (commit ? commit_bytes : '0);
      end

      // A terminate inside w7 itself has no stored latency yet; use the live one.
      if (commit) begin
        rx_latency <= (wcnt == 29'd7) ? lat_now : lat_pend;
        rx_ipv4_ip <= src_ip;
      end

      if (err_inc && rx_err_count != 16'hFFFF) rx_err_count <= rx_err_count + 16'd1;

      case (state)
        S_IDLE: begin
          if (is_start) begin
            state    <= S_HDR;
            wcnt     <= 29'd1;
            frame_ok <= 1'b1;
          end
        end
        S_HDR, S_BODY: begin
          if (is_start) begin
            state    <= S_HDR;
            wcnt     <= 29'd1;
            frame_ok <= 1'b1;
          end else if (term_ok) begin
            state <= S_IDLE;
          end else if (abort) begin
            state <= S_DROP;
          end else begin
            frame_ok <= frame_ok & chk_ok;
            wcnt     <= wcnt + 29'd1;
            if (wcnt == 29'd4) src_ip <= {lane[2], lane[3], lane[4], lane[5]};
            if (wcnt == 29'd6) ts_hi <= lane[7];
            if (wcnt == 29'd7) lat_pend <= lat_now;
            state <= (wcnt >= 29'd7) ? S_BODY : S_HDR;
          end
        end
        S_DROP: begin
          if (idle_word || is_start) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_measure_rx.sv
// Directed self-checking bench for measure_rx: table of frame vectors plus
// hand-written sequences for window-edge commit, aborts and mid-frame reset.
module tb_measure_rx;

  localparam logic [39:0] MAGIC = 40'hA1B2C3D4E5;
  localparam logic [15:0] PORT  = 16'd3422;
  localparam logic [63:0] IDLE_D = {8{8'h07}};

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        sec_oneshot;
  logic [31:0] gc;
  logic [31:0] rx_pps, rx_throughput, rx_ipv4_ip;
  logic [23:0] rx_latency;
  logic [15:0] rx_err_count;

  measure_rx_if xif();

  measure_rx #(.MAGIC_CODE(MAGIC), .UDP_PORT(PORT)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .sec_oneshot    (sec_oneshot),
    .global_counter (gc),
    .xgmii          (xif.slave),
    .rx_pps         (rx_pps),
    .rx_throughput  (rx_throughput),
    .rx_latency     (rx_latency),
    .rx_ipv4_ip     (rx_ipv4_ip),
    .rx_err_count   (rx_err_count)
  );

  always #5 sys_clk = ~sys_clk;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [63:0] fw [8];

  typedef struct {
    logic [31:0] src;
    logic [31:0] ts;
    logic [31:0] gcw;
    logic [39:0] magic;
    logic [15:0] port;
    logic [7:0]  proto;
    int unsigned n;
    int unsigned k;
    logic [31:0] exp_pps;
    logic [31:0] exp_tput;
    logic [23:0] exp_lat;
    logic [31:0] exp_ip;
  } vec_t;

  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [63:0] putb(input logic [63:0] word, input int unsigned b, input logic [7:0] v);
    logic [63:0] r;
    r = word;
    r[8*b +: 8] = v;
    return r;
  endfunction

  task automatic send_word(input logic [63:0] d, input logic [7:0] c);
    xif.xgmii_rxd = d;
    xif.xgmii_rxc = c;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic build(input logic [31:0] src, input logic [31:0] ts, input logic [39:0] magic,
                       input logic [15:0] port, input logic [7:0] proto);
    for (int w = 1; w < 8; w++) fw[w] = {8{8'h5A}};
    fw[0] = 64'hD5555555555555FB;
    fw[2] = putb(fw[2], 4, 8'h08); fw[2] = putb(fw[2], 5, 8'h00);
    fw[2] = putb(fw[2], 6, 8'h45); fw[2] = putb(fw[2], 7, 8'h00);
    fw[3] = putb(fw[3], 7, proto);
    fw[4] = putb(fw[4], 2, src[31:24]); fw[4] = putb(fw[4], 3, src[23:16]);
    fw[4] = putb(fw[4], 4, src[15:8]);  fw[4] = putb(fw[4], 5, src[7:0]);
    fw[5] = putb(fw[5], 2, port[15:8]); fw[5] = putb(fw[5], 3, port[7:0]);
    fw[5] = putb(fw[5], 4, port[15:8]); fw[5] = putb(fw[5], 5, port[7:0]);
    fw[6] = putb(fw[6], 2, magic[39:32]); fw[6] = putb(fw[6], 3, magic[31:24]);
    fw[6] = putb(fw[6], 4, magic[23:16]); fw[6] = putb(fw[6], 5, magic[15:8]);
    fw[6] = putb(fw[6], 6, magic[7:0]);   fw[6] = putb(fw[6], 7, ts[31:24]);
    fw[7] = putb(fw[7], 0, ts[23:16]); fw[7] = putb(fw[7], 1, ts[15:8]);
    fw[7] = putb(fw[7], 2, ts[7:0]);
  endtask

  task automatic send_hdr(input int from, input int to, input logic [31:0] gcw);
    for (int w = from; w <= to; w++) begin
      if (w == 7) gc = gcw;
      send_word(fw[w], (w == 0) ? 8'h01 : 8'h00);
    end
  endtask

  task automatic send_tail(input int unsigned n, input int unsigned k, input logic os);
    logic [63:0] tw;
    logic [7:0]  tc;
    for (int unsigned w = 8; w < n; w++) send_word({8{8'hA5}}, 8'h00);
    tw = IDLE_D;
    for (int unsigned i = 0; i < k; i++) tw = putb(tw, i, 8'hA5);
    tw = putb(tw, k, 8'hFD);
    tc = 8'hFF;
    tc = tc << k;
    sec_oneshot = os;
    send_word(tw, tc);
    sec_oneshot = 1'b0;
    send_word(IDLE_D, 8'hFF);
  endtask

  task automatic send_frame(input vec_t v, input logic os);
    build(v.src, v.ts, v.magic, v.port, v.proto);
    send_hdr(0, 7, v.gcw);
    send_tail(v.n, v.k, os);
  endtask

  task automatic pulse_os();
    sec_oneshot = 1'b1;
    send_word(IDLE_D, 8'hFF);
    sec_oneshot = 1'b0;
  endtask

  initial begin
    vec_t good;
    vt[0] = '{32'hC0A80105, 32'd1000, 32'd1250, MAGIC, PORT, 8'h11, 9, 4, 32'd1, 32'd68, 24'd250, 32'hC0A80105};
    vt[1] = '{32'h0A000001, 32'd1000, 32'd1250, 40'hA1B2C3D4E6, PORT, 8'h11, 9, 4, 32'd0, 32'd0, 24'd250, 32'hC0A80105};
    vt[2] = '{32'h0A000002, 32'd1000, 32'd1250, MAGIC, 16'd3423, 8'h11, 9, 4, 32'd0, 32'd0, 24'd250, 32'hC0A80105};
    vt[3] = '{32'h0A000003, 32'd1000, 32'd1250, MAGIC, PORT, 8'h06, 9, 4, 32'd0, 32'd0, 24'd250, 32'hC0A80105};
    vt[4] = '{32'h0B0C0D0E, 32'hFFFFFFF0, 32'h10, MAGIC, PORT, 8'h11, 8, 0, 32'd1, 32'd56, 24'h20, 32'h0B0C0D0E};
    vt[5] = '{32'h7F000001, 32'h0, 32'h0100_0000, MAGIC, PORT, 8'h11, 10, 7, 32'd1, 32'd79, 24'hFFFFFF, 32'h7F000001};
    good = vt[0];

    sys_rst = 1'b1;
    sec_oneshot = 1'b0;
    gc = '0;
    xif.xgmii_rxd = IDLE_D;
    xif.xgmii_rxc = 8'hFF;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    send_word(IDLE_D, 8'hFF);
    chk("reset_pps", rx_pps, 32'd0);
    chk("reset_tput", rx_throughput, 32'd0);
    chk("reset_lat", {8'd0, rx_latency}, 32'd0);
    chk("reset_ip", rx_ipv4_ip, 32'd0);
    chk("reset_err", {16'd0, rx_err_count}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      send_frame(vt[i], 1'b0);
      chk($sformatf("v%0d_lat", i), {8'd0, rx_latency}, {8'd0, vt[i].exp_lat});
      chk($sformatf("v%0d_ip", i), rx_ipv4_ip, vt[i].exp_ip);
      pulse_os();
      chk($sformatf("v%0d_pps", i), rx_pps, vt[i].exp_pps);
      chk($sformatf("v%0d_tput", i), rx_throughput, vt[i].exp_tput);
      chk($sformatf("v%0d_err", i), {16'd0, rx_err_count}, 32'd0);
    end

    // Commit coincident with the window close lands in the closing window.
    for (int i = 0; i < 3; i++) send_frame(good, 1'b0);
    send_frame(good, 1'b1);
    chk("edge_pps", rx_pps, 32'd4);
    chk("edge_tput", rx_throughput, 32'd272);
    pulse_os();
    chk("edge_next_pps", rx_pps, 32'd0);
    chk("edge_next_tput", rx_throughput, 32'd0);

    // Bad control byte at w5, then a start word inside BODY restarting the frame.
    build(good.src, good.ts, good.magic, good.port, good.proto);
    send_hdr(0, 4, good.gcw);
    send_word(putb({8{8'h5A}}, 2, 8'hFE), 8'h04);
    chk("abort1_err", {16'd0, rx_err_count}, 32'd1);
    send_word(IDLE_D, 8'hFF);
    send_hdr(0, 7, good.gcw);
    send_word({8{8'hA5}}, 8'h00);
    send_hdr(0, 7, good.gcw);
    chk("abort2_err", {16'd0, rx_err_count}, 32'd2);
    send_tail(9, 4, 1'b0);
    pulse_os();
    chk("abort_pps", rx_pps, 32'd1);
    chk("abort_tput", rx_throughput, 32'd68);
    chk("abort_err_hold", {16'd0, rx_err_count}, 32'd2);

    // Asynchronous reset in the middle of w4.
    build(good.src, good.ts, good.magic, good.port, good.proto);
    send_hdr(0, 3, good.gcw);
    xif.xgmii_rxd = fw[4];
    xif.xgmii_rxc = 8'h00;
    #2;
    sys_rst = 1'b1;
    #1;
    chk("rst_pps", rx_pps, 32'd0);
    chk("rst_tput", rx_throughput, 32'd0);
    chk("rst_lat", {8'd0, rx_latency}, 32'd0);
    chk("rst_ip", rx_ipv4_ip, 32'd0);
    chk("rst_err", {16'd0, rx_err_count}, 32'd0);
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    send_word(fw[5], 8'h00);
    send_word(IDLE_D, 8'hFF);
    send_frame(good, 1'b0);
    pulse_os();
    chk("post_rst_pps", rx_pps, 32'd1);
    chk("post_rst_tput", rx_throughput, 32'd68);
    chk("post_rst_lat", {8'd0, rx_latency}, 32'd250);
    chk("post_rst_err", {16'd0, rx_err_count}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
